// File: rtl/safe_pkg.sv
// safe_pkg: shared state encoding and width helper for the safe lock core
package safe_pkg;
   typedef enum logic [2:0] {ENTRY, CHECK, OPEN, PROGRAM, LOCKOUT} safe_state_t;
   function automatic int cnt_w(int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/safe_lock_core_if.sv
// safe_lock_core_if: keypad command inputs and status outputs of the lock core
interface safe_lock_core_if
   import safe_pkg::*;
#(
   parameter int DIGIT_W   = 4,
   parameter int CODE_LEN  = 4,
   parameter int MAX_TRIES = 3
);
   logic                         digit_valid;
   logic [DIGIT_W-1:0]           digit;
   logic                         enter;
   logic                         clear;
   logic                         lock_cmd;
   logic                         prog_en;
   logic                         unlocked;
   logic                         lockout;
   logic                         ok_pulse;
   logic                         fail_pulse;
   logic [cnt_w(CODE_LEN)-1:0]   digit_count;
   logic [cnt_w(MAX_TRIES)-1:0]  tries_left;
   modport master (
      output digit_valid, digit, enter, clear, lock_cmd, prog_en,
      input  unlocked, lockout, ok_pulse, fail_pulse, digit_count, tries_left
   );
   modport slave (
      input  digit_valid, digit, enter, clear, lock_cmd, prog_en,
      output unlocked, lockout, ok_pulse, fail_pulse, digit_count, tries_left
   );
endinterface

// File: rtl/safe_lockout_timer.sv
// safe_lockout_timer: one-shot down-counter, active for exactly LOCKOUT_CYCLES cycles after start
module safe_lockout_timer
   import safe_pkg::*;
#(
   parameter int LOCKOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic active,
   output logic done
);
   localparam int W = cnt_w(LOCKOUT_CYCLES);
   logic [W-1:0] cnt;
   assign done = active && cnt == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         active <= 1'b0;
         cnt    <= '0;
      end else if (start) begin
         active <= 1'b1;
         cnt    <= W'(LOCKOUT_CYCLES - 1);
      end else if (active) begin
         active <= !done;
         cnt    <= done ? cnt : cnt - W'(1);
      end
   end
endmodule

// File: rtl/safe_lock_core.sv
// safe_lock_core: keypad code entry, compare, failed-try lockout and code re-programming
module safe_lock_core
   import safe_pkg::*;
#(
   parameter int                            DIGIT_W        = 4,
   parameter int                            CODE_LEN       = 4,
   parameter int                            MAX_TRIES      = 3,
   parameter int                            LOCKOUT_CYCLES = 1024,
   parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234
) (
   input logic             clk,
   input logic             rst,
   safe_lock_core_if.slave bus
);
   localparam int BW = CODE_LEN * DIGIT_W;
   localparam int CW = cnt_w(CODE_LEN);
   localparam int TW = cnt_w(MAX_TRIES);
   safe_state_t   state, state_d;
   logic [BW-1:0] entry, entry_d, code, code_d;
   logic [CW-1:0] count, count_d;
   logic [TW-1:0] tries, tries_d;
   logic          ovf, ovf_d, ok_d, fail_d, start, done, collect, flush, full, match;
   assign full            = count == CW'(CODE_LEN);
   assign match           = full && !ovf && entry == code;
   assign bus.digit_count = count;
   assign bus.tries_left  = tries;
   safe_lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .active (bus.lockout),
      .done   (done)
   );
   always_comb begin
      state_d = state;
      code_d  = code;
      tries_d = tries;
      ok_d    = 1'b0;
      fail_d  = 1'b0;
      start   = 1'b0;
      collect = 1'b0;
      flush   = 1'b0;
      unique case (state)
         ENTRY:
            if (bus.clear) flush = 1'b1;
            else if (bus.enter) state_d = CHECK;
            else collect = bus.digit_valid;
         CHECK: begin
            flush = 1'b1;
            if (match) begin
               state_d = OPEN;
               ok_d    = 1'b1;
               tries_d = TW'(MAX_TRIES);
            end else begin
               fail_d  = 1'b1;
               tries_d = tries - TW'(1);
               start   = tries == TW'(1);
               state_d = start ? LOCKOUT : ENTRY;
            end
         end
         OPEN:
            state_d = bus.lock_cmd ? ENTRY : bus.prog_en ? PROGRAM : OPEN;
         PROGRAM:
            if (bus.lock_cmd) begin
               state_d = ENTRY;
               flush   = 1'b1;
            end else if (bus.clear) flush = 1'b1;
            else if (bus.enter) begin
               state_d = OPEN;
               flush   = 1'b1;
               ok_d    = full && !ovf;
               fail_d  = !ok_d;
               code_d  = ok_d ? entry : code;
            end else collect = bus.digit_valid;
         LOCKOUT:
            if (done) begin
               state_d = ENTRY;
               tries_d = TW'(MAX_TRIES);
            end
         default: state_d = ENTRY;
      endcase
      // a digit beyond CODE_LEN poisons the entry rather than shifting out the oldest
      entry_d = flush ? '0 : (collect && !full) ? (entry << DIGIT_W) | BW'(bus.digit) : entry;
      count_d = flush ? '0 : (collect && !full) ? count + CW'(1) : count;
      ovf_d   = flush ? 1'b0 : ovf | (collect && full);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ENTRY;
         entry          <= '0;
         count          <= '0;
         ovf            <= 1'b0;
         code           <= DEFAULT_CODE;
         tries          <= TW'(MAX_TRIES);
         bus.ok_pulse   <= 1'b0;
         bus.fail_pulse <= 1'b0;
         bus.unlocked   <= 1'b0;
      end else begin
         state          <= state_d;
         entry          <= entry_d;
         count          <= count_d;
         ovf            <= ovf_d;
         code           <= code_d;
         tries          <= tries_d;
         bus.ok_pulse   <= ok_d;
         bus.fail_pulse <= fail_d;
         bus.unlocked   <= state_d == OPEN || state_d == PROGRAM;
      end
   end
endmodule

// File: tb/tb_safe_lock_core.sv
// tb_safe_lock_core: vector table, directed corner sequences and random ops against a transaction-level lock model
module tb_safe_lock_core;
   localparam int LOCK = 1024;
   localparam int MAXT = 3;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   safe_lock_core_if #(.DIGIT_W(4), .CODE_LEN(4), .MAX_TRIES(MAXT)) bus ();
   safe_lock_core #(
      .DIGIT_W(4), .CODE_LEN(4), .MAX_TRIES(MAXT), .LOCKOUT_CYCLES(LOCK), .DEFAULT_CODE(16'h1234)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   int total = 0;
   int bad   = 0;
   // model: mode 0 locked/entry, 1 open, 2 programming, 3 locked out
   int m_mode, m_code, m_tries, m_left, q[$];
   bit m_ovf, m_ok, m_fail;
   typedef struct {
      bit dv; logic [3:0] d; bit en, cl, lk, pg;
      int ok, fail, unl, lck, cnt, tries;
   } vec_t;
   vec_t tv[17];
   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask
   task automatic drive(bit dv, logic [3:0] d, bit en, bit cl, bit lk, bit pg);
      bus.digit_valid = dv; bus.digit = d; bus.enter = en;
      bus.clear = cl; bus.lock_cmd = lk; bus.prog_en = pg;
      @(posedge clk); #1;
      bus.digit_valid = 0; bus.digit = '0; bus.enter = 0;
      bus.clear = 0; bus.lock_cmd = 0; bus.prog_en = 0;
   endtask
   function automatic int buf_val();
      int v = 0;
      foreach (q[i]) v = v * 16 + q[i];
      return v;
   endfunction
   function automatic void push(int d);
      if (q.size() == 4) m_ovf = 1; else q.push_back(d);
   endfunction
   function automatic void flush();
      q.delete(); m_ovf = 0;
   endfunction
   task automatic expect_all(string tag);
      chk({tag, ".ok"},       bus.ok_pulse,    m_ok);
      chk({tag, ".fail"},     bus.fail_pulse,  m_fail);
      chk({tag, ".unlocked"}, bus.unlocked,    m_mode == 1 || m_mode == 2);
      chk({tag, ".lockout"},  bus.lockout,     m_mode == 3);
      chk({tag, ".count"},    bus.digit_count, q.size());
      chk({tag, ".tries"},    bus.tries_left,  m_tries);
   endtask
   task automatic do_reset(string tag);
      rst = 1;
      drive(0, 0, 0, 0, 0, 0);
      rst = 0;
      m_mode = 0; m_code = 'h1234; m_tries = MAXT; m_left = 0;
      m_ok = 0; m_fail = 0; flush();
      expect_all(tag);
   endtask
   task automatic op(string tag, bit dv, logic [3:0] d, bit en, bit cl, bit lk, bit pg);
      m_ok = 0; m_fail = 0;
      drive(dv, d, en, cl, lk, pg);
      case (m_mode)
         0: if (cl) flush();
            else if (en) begin
               expect_all({tag, ".chk"});
               drive(0, 0, 0, 0, 0, 0);
               if (q.size() == 4 && !m_ovf && buf_val() == m_code) begin
                  m_ok = 1; m_mode = 1; m_tries = MAXT;
               end else begin
                  m_fail = 1; m_tries--;
                  if (m_tries == 0) begin m_mode = 3; m_left = LOCK; end
               end
               flush();
            end else if (dv) push(int'(d));
         1: m_mode = lk ? 0 : pg ? 2 : 1;
         2: if (lk) begin m_mode = 0; flush(); end
            else if (cl) flush();
            else if (en) begin
               if (q.size() == 4 && !m_ovf) begin m_code = buf_val(); m_ok = 1; end
               else m_fail = 1;
               m_mode = 1; flush();
            end else if (dv) push(int'(d));
         default: begin
            m_left--;
            if (m_left == 0) begin m_mode = 0; m_tries = MAXT; end
         end
      endcase
      expect_all(tag);
   endtask
   task automatic code_in(string tag, int c, int nd);
      for (int i = 0; i < nd; i++) op(tag, 1, 4'(c >> (4 * (nd - 1 - i))), 0, 0, 0, 0);
      op({tag, ".enter"}, 0, 0, 1, 0, 0, 0);
   endtask
   initial begin
      int n;
      bus.digit_valid = 0; bus.digit = '0; bus.enter = 0;
      bus.clear = 0; bus.lock_cmd = 0; bus.prog_en = 0;
      tv[0]  = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 3};
      tv[1]  = '{1, 2, 0, 0, 0, 0,  0, 0, 0, 0, 2, 3};
      tv[2]  = '{1, 3, 0, 0, 0, 0,  0, 0, 0, 0, 3, 3};
      tv[3]  = '{1, 4, 0, 0, 0, 0,  0, 0, 0, 0, 4, 3};
      tv[4]  = '{0, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4, 3};
      tv[5]  = '{0, 0, 0, 0, 0, 0,  1, 0, 1, 0, 0, 3};
      tv[6]  = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3};
      tv[7]  = '{1, 5, 0, 0, 0, 0,  0, 0, 1, 0, 0, 3};
      tv[8]  = '{0, 0, 0, 0, 0, 1,  0, 0, 1, 0, 0, 3};
      tv[9]  = '{1, 9, 0, 0, 0, 0,  0, 0, 1, 0, 1, 3};
      tv[10] = '{0, 0, 1, 0, 0, 0,  0, 1, 1, 0, 0, 3};
      tv[11] = '{0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 3};
      tv[12] = '{1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0, 3};
      tv[13] = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 2};
      tv[14] = '{1, 1, 0, 0, 0, 0,  0, 0, 0, 0, 1, 2};
      tv[15] = '{0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 2};
      tv[16] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2};
      do_reset("reset");
      foreach (tv[i]) begin
         drive(tv[i].dv, tv[i].d, tv[i].en, tv[i].cl, tv[i].lk, tv[i].pg);
         chk($sformatf("vec%0d.ok", i),       bus.ok_pulse,    tv[i].ok);
         chk($sformatf("vec%0d.fail", i),     bus.fail_pulse,  tv[i].fail);
         chk($sformatf("vec%0d.unlocked", i), bus.unlocked,    tv[i].unl);
         chk($sformatf("vec%0d.lockout", i),  bus.lockout,     tv[i].lck);
         chk($sformatf("vec%0d.count", i),    bus.digit_count, tv[i].cnt);
         chk($sformatf("vec%0d.tries", i),    bus.tries_left,  tv[i].tries);
      end
      do_reset("reset2");
      code_in("open1234", 'h1234, 4);
      op("relock", 0, 0, 0, 0, 1, 0);
      for (int k = 0; k < 3; k++) code_in($sformatf("bad%0d", k), 'h1235, 4);
      n = bus.lockout ? 1 : 0;
      for (int i = 0; i < LOCK + 50 && bus.lockout; i++) begin
         op("lockwait", i % 4 == 0, 4'(i % 10), i % 7 == 0, 0, 0, 0);
         if (bus.lockout) n++;
      end
      chk("lockout_len", n, LOCK);
      code_in("overflow", 'h12344, 5);
      op("part1", 1, 1, 0, 0, 0, 0);
      op("part2", 1, 2, 0, 0, 0, 0);
      op("clear", 0, 0, 0, 1, 0, 0);
      code_in("after_clear", 'h1234, 4);
      op("prog", 0, 0, 0, 0, 0, 1);
      code_in("prog9876", 'h9876, 4);
      op("relock2", 0, 0, 0, 0, 1, 0);
      code_in("old_code", 'h1234, 4);
      code_in("new_code", 'h9876, 4);
      op("prog2", 0, 0, 0, 0, 0, 1);
      code_in("prog55", 'h55, 2);
      op("relock3", 0, 0, 0, 0, 1, 0);
      code_in("still9876", 'h9876, 4);
      chk("still9876.open", bus.unlocked, 1);
      op("relock4", 0, 0, 0, 0, 1, 0);
      op("dv_enter", 1, 1, 1, 0, 0, 0);
      op("clr_enter", 1, 2, 1, 1, 0, 0);
      do_reset("reset3");
      for (int k = 0; k < 3; k++) code_in($sformatf("lk%0d", k), 'h4321, 4);
      for (int i = 0; i < 20; i++) op("midlock", 1, 4'(i), 0, 0, 0, 0);
      do_reset("reset_midlock");
      code_in("default_again", 'h1234, 4);
      op("prog3", 0, 0, 0, 0, 0, 1);
      code_in("prog1111", 'h1111, 4);
      do_reset("reset_prog");
      code_in("reverted", 'h1234, 4);
      chk("reverted.open", bus.unlocked, 1);
      for (int i = 0; i < 1500; i++) begin
         int r, pos;
         logic [3:0] d;
         r = $urandom_range(0, 99);
         pos = q.size();
         d = ($urandom_range(0, 4) == 0 || pos >= 4) ? 4'($urandom) : 4'(m_code >> (4 * (3 - pos)));
         if ((m_mode == 3 && $urandom_range(0, 1) == 0) || r < 2) do_reset("rnd_rst");
         else if (r < 50) op("rnd_digit", 1, d, 0, 0, 0, 0);
         else if (r < 62) op("rnd_enter", 0, 0, 1, 0, 0, 0);
         else if (r < 67) op("rnd_clear", 0, 0, 0, 1, 0, 0);
         else if (r < 73) op("rnd_lock", 0, 0, 0, 0, 1, 0);
         else if (r < 83) op("rnd_prog", 0, 0, 0, 0, 0, 1);
         else if (r < 90) op("rnd_idle", 0, 0, 0, 0, 0, 0);
         else op("rnd_mix", 1'($urandom), d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
